// File: rtl/stream_pkg.sv
// Shared definitions for the narrow/wide stream converters: lane index sizing
// and the downsizer's state encoding.
package stream_pkg;

  // A lane index is at least one bit wide so that ratio-1 configurations still elaborate.
  function automatic int lane_idx_w(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  typedef enum logic {
    DSZ_EMPTY = 1'b0,
    DSZ_SEND  = 1'b1
  } dsz_state_t;

endpackage

// File: rtl/stream_lane_ffs.sv
// Find-first-set over a lane mask: reports the lowest set lane index and
// whether any lane is set at all.
module stream_lane_ffs
  import stream_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = lane_idx_w(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    // NOTE: idx gets a default before the loop, so no path leaves it unassigned (no latch).
    idx = '0;
    // Scan downward so the lowest set bit is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream serializer: emits the kept lanes of each wide beat as
// narrow beats, lowest lane first, with last on the final kept lane of a packet.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IW = lane_idx_w(T_DATA_RATIO);

  dsz_state_t              state;
  logic [T_DATA_WIDTH-1:0] hold_data [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] hold_mask;
  logic                    hold_last;

  logic [T_DATA_RATIO-1:0] rest_mask;
  logic [IW-1:0]           cur_idx;
  logic [IW-1:0]           rest_idx;
  logic                    cur_any;
  logic                    rest_any;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    load;

  stream_lane_ffs #(.N(T_DATA_RATIO)) u_cur_ffs (
    .vec (hold_mask),
    .idx (cur_idx),
    .any (cur_any)
  );

  always_comb begin
    rest_mask          = hold_mask;
    rest_mask[cur_idx] = 1'b0;
  end

  // Only the "anything left after this lane" flag is needed from the second scan.
  stream_lane_ffs #(.N(T_DATA_RATIO)) u_rest_ffs (
    .vec (rest_mask),
    .idx (rest_idx),
    .any (rest_any)
  );

  assign m_valid_o = (state == DSZ_SEND);
  // hold_mask is zero whenever the block is empty, so cur_any gates stale lane data to zero.
  assign m_data_o  = cur_any ? hold_data[cur_idx] : '0;
  assign m_last_o  = cur_any & hold_last & ~rest_any;

  assign out_xfer  = m_valid_o & m_ready_i;
  assign s_ready_o = (state == DSZ_EMPTY) | (out_xfer & ~rest_any);
  assign in_xfer   = s_valid_i & s_ready_o;
  assign load      = in_xfer & (|s_keep_i);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DSZ_EMPTY;
      hold_mask <= '0;
      hold_last <= 1'b0;
    end else begin
      case (state)
        DSZ_EMPTY: begin
          if (load) begin
            state     <= DSZ_SEND;
            hold_mask <= s_keep_i;
            hold_last <= s_last_i;
          end
        end
        DSZ_SEND: begin
          if (out_xfer) begin
            if (rest_any) begin
              hold_mask <= rest_mask;
            end else if (load) begin
              hold_mask <= s_keep_i;
              hold_last <= s_last_i;
            end else begin
              state     <= DSZ_EMPTY;
              hold_mask <= '0;
            end
          end
        end
      endcase
    end
  end

  // NOTE: lane storage has no reset; an all-zero hold_mask already hides whatever it holds.
  always_ff @(posedge clk) begin
    if (load) hold_data <= s_data_i;
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Randomized and directed bench for stream_downsize against a lane-queue
// reference model.
module tb_stream_downsize;

  localparam int W = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_data_i [R-1:0];
  logic [R-1:0] s_keep_i;
  logic         s_last_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [W-1:0] m_data_o;
  logic         m_last_o;
  logic         m_valid_o;
  logic         m_ready_i;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } lane_t;

  lane_t q[$];
  bit    rand_ready = 1'b0;
  bit    in_x = 1'b0;
  bit    out_x = 1'b0;

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_keep_i  (s_keep_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every kept lane becomes one queued output; last rides on the highest kept lane.
  function automatic void push_beat(input logic [W-1:0] d [R-1:0], input logic [R-1:0] k,
                                    input logic l);
    int hi = -1;
    for (int i = 0; i < R; i++) if (k[i]) hi = i;
    for (int i = 0; i < R; i++) begin
      if (k[i]) begin
        lane_t e;
        e.d = d[i];
        e.l = l && (i == hi);
        q.push_back(e);
      end
    end
  endfunction

  // Mid-cycle monitor: outputs follow from the queue of lanes still owed.
  always @(negedge clk) begin
    bit ev;
    bit er;
    if (rst_n) begin
      ev = (q.size() != 0);
      er = !ev || (m_ready_i && q.size() == 1);
      check("m_valid", m_valid_o, ev);
      check("s_ready", s_ready_o, er);
      if (ev) begin
        check("m_data", m_data_o, q[0].d);
        check("m_last", m_last_o, q[0].l);
      end
      in_x  = s_valid_i && er;
      out_x = ev && m_ready_i;
    end else begin
      in_x  = 1'b0;
      out_x = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (out_x) void'(q.pop_front());
      if (in_x) push_beat(s_data_i, s_keep_i, s_last_i);
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) m_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic send_beat(input logic [W-1:0] d [R-1:0], input logic [R-1:0] k, input logic l);
    bit acc = 1'b0;
    s_data_i  = d;
    s_keep_i  = k;
    s_last_i  = l;
    s_valid_i = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    s_valid_i = 1'b0;
  endtask

  task automatic beat4(input logic [4*W-1:0] lanes, input logic [R-1:0] k, input logic l);
    logic [W-1:0] bd [R-1:0];
    for (int i = 0; i < R; i++) bd[i] = lanes[i*W +: W];
    send_beat(bd, k, l);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 2000 && q.size() != 0; n++) cycles(1);
    check(tag, q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, m_valid_o, 1'b0);
    check({tag, "_last"},  m_last_o,  1'b0);
    check({tag, "_data"},  m_data_o,  '0);
    check({tag, "_ready"}, s_ready_o, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < R; i++) s_data_i[i] = '0;
    s_keep_i  = '0;
    s_last_i  = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;

    cycles(2);
    check_reset_outputs("por");
    rst_n = 1'b1;
    cycles(1);

    // Two lanes, then back-to-back beats with no bubble.
    beat4(16'h00BA, 4'b0011, 1'b1);
    drain("drain_basic");
    beat4(16'h00BA, 4'b0011, 1'b0);
    beat4(16'h00DC, 4'b0011, 1'b1);
    drain("drain_b2b");

    // Single-lane beats: the next beat is taken while the only lane leaves.
    beat4(16'h0005, 4'b0001, 1'b1);
    beat4(16'h0007, 4'b0001, 1'b1);
    drain("drain_single");

    // Sparse mask skips holes.
    beat4(16'h3210, 4'b1010, 1'b1);
    drain("drain_sparse");

    // Backpressure holds the presented lane steady.
    m_ready_i = 1'b0;
    beat4(16'h00BA, 4'b0011, 1'b1);
    cycles(3);
    check("bp_data", m_data_o, 4'hA);
    check("bp_ready", s_ready_o, 1'b0);
    m_ready_i = 1'b1;
    drain("drain_bp");

    // Zero-keep beat is swallowed.
    beat4(16'h00FF, 4'b0000, 1'b0);
    cycles(2);
    check("zero_keep_valid", m_valid_o, 1'b0);

    // Asynchronous reset in the middle of a beat drops the unsent lanes.
    m_ready_i = 1'b0;
    beat4(16'h00BA, 4'b0011, 1'b1);
    m_ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    q.delete();
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    check_reset_outputs("post_rst");

    // Random traffic with random backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 300; b++) begin
      logic [R-1:0] k;
      k = R'($urandom_range(0, (1 << R) - 1));
      beat4(16'($urandom), k, (k != 0) ? 1'($urandom) : 1'b0);
      cycles($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    m_ready_i  = 1'b1;
    drain("drain_random");
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
